// File: rtl/qspi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : qspi_master_param
// Brief    : Full-duplex single/dual/quad SPI master (CPOL=0, CPHA=0) with
//            programmable SCLK divider, CS setup/hold and start/busy/done.
// Revision : 1.0
// ============================================================================
module qspi_master_param #(
    parameter int DATA_W       = 8,
    parameter int NUM_CS       = 1,
    parameter int CLK_DIV      = 1,
    parameter int CS_SETUP_CYC = 1,
    parameter int CS_HOLD_CYC  = 1,
    localparam int SEL_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  slave_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic [3:0]        mosi,
    input  logic [3:0]        miso
);

    localparam int C_MAX_A = (CS_SETUP_CYC > CLK_DIV) ? CS_SETUP_CYC : CLK_DIV;
    localparam int C_MAX   = (C_MAX_A > CS_HOLD_CYC) ? C_MAX_A : CS_HOLD_CYC;
    localparam int CNT_W   = $clog2(C_MAX + 1);
    localparam int SYM_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SYM_W-1:0]  r_sym;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_sclk;
    logic [NUM_CS-1:0] r_cs_n;
    logic [3:0]        r_mosi;

    logic [DATA_W-1:0] w_tx_next;
    logic [DATA_W-1:0] w_rx_next;
    logic [SYM_W-1:0]  w_last;
    logic              w_legal;
    logic [NUM_CS-1:0] w_sel_mask;

    // Map the top K bits of a word onto lanes K-1..0 (highest used lane = MSB).
    function automatic logic [3:0] f_sym(input logic [3:0] top, input logic [1:0] m);
        logic [3:0] v;
        case (m)
            2'b00:   v = {3'b000, top[3]};
            2'b01:   v = {2'b00, top[3:2]};
            default: v = top;
        endcase
        return v;
    endfunction

    assign w_legal    = (mode != 2'b11) && (32'(slave_sel) < NUM_CS);
    assign w_sel_mask = NUM_CS'(1) << slave_sel;

    always_comb begin
        w_tx_next = r_tx;
        w_rx_next = r_rx;
        w_last    = '0;
        case (r_mode)
            2'b00: begin
                w_tx_next = r_tx << 1;
                w_rx_next = (r_rx << 1) | DATA_W'(miso[0]);
                w_last    = SYM_W'(DATA_W - 1);
            end
            2'b01: begin
                w_tx_next = r_tx << 2;
                w_rx_next = (r_rx << 2) | DATA_W'(miso[1:0]);
                w_last    = SYM_W'(DATA_W / 2 - 1);
            end
            default: begin
                w_tx_next = r_tx << 4;
                w_rx_next = (r_rx << 4) | DATA_W'(miso);
                w_last    = SYM_W'(DATA_W / 4 - 1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sym     <= '0;
            r_mode    <= 2'b00;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= '1;
            r_mosi    <= 4'h0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy is still high in the done cycle; new starts wait one cycle.
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        if (w_legal) begin
                            r_state <= S_SETUP;
                            r_busy  <= 1'b1;
                            r_mode  <= mode;
                            r_tx    <= tx_data;
                            r_rx    <= '0;
                            r_cnt   <= '0;
                            r_sym   <= '0;
                            r_cs_n  <= ~w_sel_mask;
                            r_mosi  <= f_sym(tx_data[DATA_W-1 -: 4], mode);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CNT_W'(CS_SETUP_CYC)) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_rx <= w_rx_next;
                        end else if (r_sym == w_last) begin
                            r_state <= S_HOLD;
                            r_mosi  <= 4'h0;
                        end else begin
                            r_sym  <= r_sym + SYM_W'(1);
                            r_tx   <= w_tx_next;
                            r_mosi <= f_sym(w_tx_next[DATA_W-1 -: 4], r_mode);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(CS_HOLD_CYC - 1)) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_cs_n    <= '1;
                        r_rx_data <= r_rx;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign sclk    = r_sclk;
    assign cs_n    = r_cs_n;
    assign mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_qspi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_master_param
// Brief    : Scoreboard bench for qspi_master_param (8-bit/3-CS and 16-bit/4-CS).
// Revision : 1.0
// ============================================================================
module tb_qspi_master_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_start, a_busy, a_done, a_err, a_sclk, a_loop;
    logic [1:0] a_mode, a_sel;
    logic [7:0] a_tx, a_rx;
    logic [2:0] a_cs;
    logic [3:0] a_mosi, a_miso;
    logic [3:0] a_pat [16];
    int         a_rises;

    logic        b_start, b_busy, b_done, b_err, b_sclk;
    logic [1:0]  b_mode, b_sel;
    logic [15:0] b_tx, b_rx;
    logic [3:0]  b_cs, b_mosi, b_miso;
    logic [3:0]  b_pat [16];
    int          b_rises;

    assign a_miso = a_loop ? a_mosi : a_pat[a_rises[3:0]];
    assign b_miso = b_pat[b_rises[3:0]];

    qspi_master_param #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(1), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .mode(a_mode), .slave_sel(a_sel),
        .tx_data(a_tx), .rx_data(a_rx), .busy(a_busy), .done(a_done), .err(a_err),
        .sclk(a_sclk), .cs_n(a_cs), .mosi(a_mosi), .miso(a_miso));

    qspi_master_param #(.DATA_W(16), .NUM_CS(4), .CLK_DIV(3), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .slave_sel(b_sel),
        .tx_data(b_tx), .rx_data(b_rx), .busy(b_busy), .done(b_done), .err(b_err),
        .sclk(b_sclk), .cs_n(b_cs), .mosi(b_mosi), .miso(b_miso));

    typedef struct {
        logic [15:0] rx;
        int          lat;
        int          rises;
        logic [63:0] syms;
        logic [3:0]  cs;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transfer monitor for DUT A: records latency, symbols and active CS, checks on done.
    int          a_cyc = 0, a_t0 = 0, a_nerr = 0;
    logic        a_pb = 1'b0, a_ps = 1'b0;
    logic [63:0] a_syms = '0;
    logic [3:0]  a_csr = '0;
    always @(negedge clk) begin
        a_cyc++;
        if (reset) begin
            a_pb = 1'b0; a_ps = 1'b0; a_rises = 0;
        end else begin
            if (a_busy && !a_pb) begin
                a_t0 = a_cyc; a_rises = 0; a_syms = '0; a_csr = '0;
            end
            if (a_sclk && !a_ps) begin
                a_syms = {a_syms[59:0], a_mosi};
                a_rises++;
                a_csr = {1'b0, a_cs};
            end
            if (a_err) a_nerr++;
            if (a_done) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rx", a_rx, ea.rx);
                    chk("a_latency", a_cyc - a_t0, ea.lat);
                    chk("a_rises", a_rises, ea.rises);
                    chk("a_mosi_syms", a_syms, ea.syms);
                    chk("a_cs_active", a_csr, ea.cs);
                    chk("a_cs_release", a_cs, 3'h7);
                end
            end
            a_pb = a_busy; a_ps = a_sclk;
        end
    end

    int          b_cyc = 0, b_t0 = 0;
    logic        b_pb = 1'b0, b_ps = 1'b0;
    logic [63:0] b_syms = '0;
    logic [3:0]  b_csr = '0;
    always @(negedge clk) begin
        b_cyc++;
        if (reset) begin
            b_pb = 1'b0; b_ps = 1'b0; b_rises = 0;
        end else begin
            if (b_busy && !b_pb) begin
                b_t0 = b_cyc; b_rises = 0; b_syms = '0; b_csr = '0;
            end
            if (b_sclk && !b_ps) begin
                b_syms = {b_syms[59:0], b_mosi};
                b_rises++;
                b_csr = b_cs;
            end
            if (b_err) chk("b_unexpected_err", 1, 0);
            if (b_done) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_rx", b_rx, eb.rx);
                    chk("b_latency", b_cyc - b_t0, eb.lat);
                    chk("b_rises", b_rises, eb.rises);
                    chk("b_mosi_syms", b_syms, eb.syms);
                    chk("b_cs_active", b_csr, eb.cs);
                    chk("b_cs_release", b_cs, 4'hF);
                end
            end
            b_pb = b_busy; b_ps = b_sclk;
        end
    end

    // sel: 0 a_busy, 1 a_done, 2 b_busy, 3 b_done, 4 a_sclk, 5 !a_busy
    task automatic wait_for(input int sel, input int maxc, input string nm);
        int n = 0;
        bit hit = 1'b0;
        while (n < maxc && !hit) begin
            @(negedge clk);
            n++;
            case (sel)
                0: hit = a_busy;
                1: hit = a_done;
                2: hit = b_busy;
                3: hit = b_done;
                4: hit = a_sclk;
                default: hit = !a_busy;
            endcase
        end
        if (!hit) chk({"timeout_", nm}, 0, 1);
    endtask

    task automatic push_a(input logic [7:0] rx, input int lat, input int rises,
                          input logic [63:0] syms, input logic [3:0] cs);
        exp_t e;
        e.rx = {8'h00, rx}; e.lat = lat; e.rises = rises; e.syms = syms; e.cs = cs;
        qa.push_back(e);
    endtask

    int nerr_before;

    initial begin
        a_start = 0; a_mode = 0; a_sel = 0; a_tx = 0; a_loop = 0;
        b_start = 0; b_mode = 0; b_sel = 0; b_tx = 0;
        for (int i = 0; i < 16; i++) begin a_pat[i] = 4'h0; b_pat[i] = 4'h0; end
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_cs_n", a_cs, 3'h7);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_rx", a_rx, 0);
        chk("rst_done_err", {a_done, a_err}, 0);
        chk("rst_b_cs_n", b_cs, 4'hF);
        reset = 0;
        @(negedge clk);

        // Quad 0xA5, miso 3 then C
        a_pat[0] = 4'h3; a_pat[1] = 4'hC;
        a_mode = 2'b10; a_sel = 2'd0; a_tx = 8'hA5;
        push_a(8'h3C, 7, 2, 64'hA5, 4'h6);
        a_start = 1;
        wait_for(0, 10, "quad_busy");
        a_start = 0; a_tx = 8'h00; a_mode = 2'b00;
        wait_for(1, 30, "quad_done");

        // Single loopback 0x81 on cs 1
        a_loop = 1; a_mode = 2'b00; a_sel = 2'd1; a_tx = 8'h81;
        push_a(8'h81, 19, 8, 64'h10000001, 4'h5);
        a_start = 1;
        wait_for(0, 10, "single_busy");
        a_start = 0;
        wait_for(1, 40, "single_done");
        @(negedge clk);

        // Illegal mode, then out-of-range select
        a_mode = 2'b11; a_sel = 2'd0; a_start = 1;
        @(negedge clk);
        chk("err_mode_pulse", a_err, 1);
        chk("err_mode_busy", a_busy, 0);
        chk("err_mode_cs", a_cs, 3'h7);
        a_start = 0;
        @(negedge clk);
        chk("err_mode_one_cycle", a_err, 0);
        a_mode = 2'b00; a_sel = 2'd3; a_start = 1;
        @(negedge clk);
        chk("err_sel_pulse", a_err, 1);
        chk("err_sel_cs", {a_busy, a_cs}, 4'h7);
        a_start = 0;
        @(negedge clk);

        // Dual loopback 0x6C on cs 2, start re-pulsed mid-shift
        a_mode = 2'b01; a_sel = 2'd2; a_tx = 8'h6C;
        push_a(8'h6C, 11, 4, 64'h1230, 4'h3);
        a_start = 1;
        wait_for(0, 10, "dual_busy");
        a_start = 0;
        wait_for(4, 10, "dual_sclk");
        nerr_before = a_nerr;
        a_start = 1; a_mode = 2'b11;
        @(negedge clk);
        a_start = 0;
        wait_for(1, 30, "dual_done");
        repeat (4) @(negedge clk);
        chk("busy_start_no_err", a_nerr, nerr_before);

        // Three back-to-back quad loopback transfers with start held
        a_mode = 2'b10; a_sel = 2'd0; a_tx = 8'h12;
        push_a(8'h12, 7, 2, 64'h12, 4'h6);
        push_a(8'h34, 7, 2, 64'h34, 4'h6);
        push_a(8'h56, 7, 2, 64'h56, 4'h6);
        a_start = 1;
        wait_for(0, 10, "b2b_busy0");
        a_tx = 8'h34;
        wait_for(1, 30, "b2b_done0");
        wait_for(5, 5, "b2b_gap0");
        chk("b2b_gap0_cs", a_cs, 3'h7);
        wait_for(0, 5, "b2b_busy1");
        a_tx = 8'h56;
        wait_for(1, 30, "b2b_done1");
        wait_for(5, 5, "b2b_gap1");
        chk("b2b_gap1_cs", a_cs, 3'h7);
        wait_for(0, 5, "b2b_busy2");
        a_tx = 8'hFF;
        wait_for(1, 30, "b2b_done2");
        a_start = 0;
        repeat (4) @(negedge clk);
        chk("b2b_idle_after", a_busy, 0);

        // Reset mid-shift: transfer aborts without done
        a_loop = 0; a_mode = 2'b00; a_sel = 2'd1; a_tx = 8'hFF;
        a_start = 1;
        wait_for(0, 10, "abort_busy");
        a_start = 0;
        wait_for(4, 10, "abort_sclk");
        reset = 1;
        @(negedge clk);
        chk("abort_sclk_low", a_sclk, 0);
        chk("abort_cs_n", a_cs, 3'h7);
        chk("abort_busy", a_busy, 0);
        chk("abort_mosi_rx", {a_mosi, a_rx}, 12'h000);
        reset = 0;
        repeat (30) @(negedge clk);

        // DUT B: dual 16-bit, divider 3, cs 2 of 4; inputs changed mid-transfer
        for (int i = 0; i < 8; i++) b_pat[i] = 4'((i < 4) ? i : 7 - i);
        b_mode = 2'b01; b_sel = 2'd2; b_tx = 16'hC3F0;
        begin
            exp_t e;
            e.rx = 16'h1BE4; e.lat = 51; e.rises = 8; e.syms = 64'h30033300; e.cs = 4'hB;
            qb.push_back(e);
        end
        b_start = 1;
        wait_for(2, 10, "b_busy");
        b_start = 0; b_mode = 2'b10; b_sel = 2'd0; b_tx = 16'h0000;
        wait_for(3, 100, "b_done");
        repeat (4) @(negedge clk);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
